uart_cmd_sender: RTL and testbench
==================================

# uart_cmd_sender

Host-side initiator for the oscilloscope's 24-bit UART command protocol. It accepts a 24-bit command and serialises it as three bytes, MSB first, over the byte interface of a UART transmitter. It then waits for a single response byte from a UART receiver and reports it, with a timeout if none arrives. It is the other end of the command link and sits in the test harness / host model, driving the same byte-level handshake (trmt/tx_done, rdy/clr_rdy) the UART core exposes.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: clk cycles allowed in WAIT_RESP before giving up; must be ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- cmd  input  24  command word; sampled only on acceptance
- send_cmd  input  1  request; accepted only in IDLE
- busy  output  1  high from the cycle after acceptance until return to IDLE
- trmt  output  1  one-cycle pulse to the UART transmitter
- tx_data  output  8  byte to transmit; stable from trmt until the next trmt
- tx_done  input  1  transmitter byte-complete level, cleared by the transmitter on trmt
- rdy  input  1  receiver byte-available level
- rx_data  input  8  received byte, valid while rdy is high
- clr_rdy  output  1  one-cycle pulse clearing the receiver's rdy
- resp_rdy  output  1  response captured; held until the next acceptance
- resp  output  8  captured response byte
- resp_ack  output  1  resp == ACK_BYTE (8'hA5); qualified by resp_rdy
- timeout  output  1  sticky; no response within TIMEOUT_CYCLES; cleared on next acceptance

## Operation
- States: IDLE, SEND, WAIT_TX, WAIT_RESP.
- **IDLE**
  - On send_cmd=1: latch cmd, set byte index to 0, and pulse clr_rdy to flush any stale byte.
  - In the same acceptance, clear resp_rdy, resp_ack and timeout. resp keeps its old value.
  - Go to SEND.
- **SEND**
  - Drive tx_data = byte[idx], where byte0 = cmd[23:16], byte1 = cmd[15:8], byte2 = cmd[7:0].
  - Assert trmt for exactly this one cycle, then go to WAIT_TX.
- **WAIT_TX**
  - Ignore tx_done in the first cycle after trmt, because the transmitter's clear may lag.
  - On tx_done=1 with idx<2: increment idx and go to SEND.
  - On tx_done=1 with idx==2: clear the timeout counter and go to WAIT_RESP.
- **WAIT_RESP**
  - The counter increments every cycle.
  - On rdy=1: latch rx_data into resp, set resp_rdy, set resp_ack = (rx_data==8'hA5), pulse clr_rdy, and go to IDLE.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: set timeout and go to IDLE.
  - If rdy and the terminal count occur in the same cycle, rdy wins and timeout stays 0.
- send_cmd while busy is ignored; there is no queue.
- A byte arriving on rdy outside WAIT_RESP is not captured; it is flushed at the next acceptance.
- Counter width is $clog2(TIMEOUT_CYCLES). The counter saturates and never wraps.

## Timing
- **Reset:** state IDLE; busy, trmt, clr_rdy, resp_rdy, resp_ack and timeout are 0; tx_data=8'h00; resp=8'h00; idx and counter are 0.
- **Reset mid-operation:** takes effect at the next edge. No further trmt is issued; a byte already in the UART may finish but is not followed.
- **Acceptance:**
  - send_cmd is sampled high in IDLE at edge 0.
  - At edge 1: busy=1, trmt=1 and tx_data=cmd[23:16].
  - clr_rdy=1 is visible for the single cycle between edges 0 and 1.
- **Byte-to-byte:** tx_done is sampled high at edge N (N ≥ trmt edge + 2). The next trmt is asserted at edge N+1.
- **Response:**
  - rdy is sampled high at edge M.
  - At edge M+1: resp_rdy=1, resp valid, clr_rdy=1 for one cycle, busy=0.
- **Timeout:** timeout=1 exactly TIMEOUT_CYCLES cycles after WAIT_RESP entry; busy falls in the same cycle.
- **Back-to-back:** a new command can be accepted in the first IDLE cycle after completion.
- All outputs are registered.

## Structure
- Shared package uart_cmd_pkg holds:
  - state enum (IDLE, SEND, WAIT_TX, WAIT_RESP)
  - ACK_BYTE = 8'hA5
  - NAK_BYTE = 8'hEE
  - CMD_BYTES = 3
- One sub-module is natural: resp_timer, a parameterised saturating counter with clear, enable and a terminal-count flag.
- Byte select is a 3:1 mux inline.

## Test plan
- **Send command:** cmd=24'h12_34_56 with a UART tx model (tx_done 10 cycles after trmt).
  - Exactly three trmt pulses, with tx_data 8'h12, 8'h34, 8'h56 in that order.
  - busy is high throughout.
- **ACK response:** after the third tx_done, rdy=1 with rx_data=8'hA5 after 50 cycles.
  - Next cycle: resp=8'hA5, resp_rdy=1, resp_ack=1, clr_rdy pulses once, busy=0.
- **Timeout:** TIMEOUT_CYCLES=100, no rdy.
  - timeout=1 and busy=0 exactly 100 cycles after WAIT_RESP entry; resp_rdy=0.
  - A following send_cmd clears timeout.
- **Ignored and stale inputs:**
  - send_cmd pulsed mid-transfer with cmd=24'hFF_FF_FF: no extra trmt, and tx_data never shows 8'hFF.
  - A stale rdy before acceptance: clr_rdy pulses at acceptance.
- **Simultaneous rdy and timeout:** rdy rises with rx_data=8'hEE on the terminal-count cycle.
  - resp=8'hEE, resp_rdy=1, resp_ack=0, timeout=0.
- **Reset mid-transfer:** rst=1 for 1 cycle after the first trmt.
  - All outputs return to their reset values; no second trmt.
  - A new command then sends correctly.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the 24-bit UART command initiator.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_TX   = 2'd2,
    WAIT_RESP = 2'd3
  } state_t;

  typedef logic [1:0] byte_idx_t;

  localparam logic [7:0] ACK_BYTE  = 8'hA5;
  localparam logic [7:0] NAK_BYTE  = 8'hEE;
  localparam int         CMD_BYTES = 3;
  localparam byte_idx_t  LAST_IDX  = byte_idx_t'(CMD_BYTES - 1);

endpackage

// File: rtl/uart_cmd_sender_resp_timer.sv
// Saturating up-counter with clear, enable and terminal-count flag; bounds the
// wait for a response byte.
module resp_timer
  import uart_cmd_pkg::*;
#(
  parameter int WIDTH    = 20,
  parameter int TC_VALUE = 999_999
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] TC = WIDTH'(TC_VALUE);

  logic [WIDTH-1:0] r_count;

  // Holds at the terminal value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != TC)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TC);

endmodule

// File: rtl/uart_cmd_sender.sv
// Sends a 24-bit command as three bytes (MSB first) over a UART byte handshake,
// then captures one response byte or flags a timeout.
//
// state     | meaning
// IDLE      | waiting for send_cmd; last result held on resp/resp_rdy/timeout
// SEND      | trmt high for one cycle with the current byte on tx_data
// WAIT_TX   | waiting for tx_done (first cycle ignored, clear may lag)
// WAIT_RESP | waiting for rdy, bounded by the response timer
module uart_cmd_sender
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] cmd,
  input  logic        send_cmd,
  output logic        busy,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  input  logic        rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  output logic        resp_ack,
  output logic        timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t    r_state, w_state_nxt;
  logic [23:0] r_cmd, w_cmd_nxt;
  byte_idx_t r_idx, w_idx_nxt;
  logic      r_tx_skip, w_tx_skip_nxt;

  logic       r_busy, w_busy_nxt;
  logic       r_trmt, w_trmt_nxt;
  logic [7:0] r_tx_data, w_tx_data_nxt;
  logic       r_clr_rdy, w_clr_rdy_nxt;
  logic       r_resp_rdy, w_resp_rdy_nxt;
  logic [7:0] r_resp, w_resp_nxt;
  logic       r_resp_ack, w_resp_ack_nxt;
  logic       r_timeout, w_timeout_nxt;

  logic w_tx_accept;
  logic w_timer_clr;
  logic w_timer_en;
  logic w_timer_tc;

  assign w_tx_accept = (r_state == WAIT_TX) && !r_tx_skip && tx_done;
  assign w_timer_en  = (r_state == WAIT_RESP);

  resp_timer #(
    .WIDTH    (CNT_W),
    .TC_VALUE (TIMEOUT_CYCLES - 1)
  ) u_resp_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_timer_clr),
    .i_en  (w_timer_en),
    .o_tc  (w_timer_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cmd      <= '0;
      r_idx      <= '0;
      r_tx_skip  <= 1'b0;
      r_busy     <= 1'b0;
      r_trmt     <= 1'b0;
      r_tx_data  <= 8'h00;
      r_clr_rdy  <= 1'b0;
      r_resp_rdy <= 1'b0;
      r_resp     <= 8'h00;
      r_resp_ack <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd      <= w_cmd_nxt;
      r_idx      <= w_idx_nxt;
      r_tx_skip  <= w_tx_skip_nxt;
      r_busy     <= w_busy_nxt;
      r_trmt     <= w_trmt_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_clr_rdy  <= w_clr_rdy_nxt;
      r_resp_rdy <= w_resp_rdy_nxt;
      r_resp     <= w_resp_nxt;
      r_resp_ack <= w_resp_ack_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (send_cmd) w_state_nxt = SEND;
      SEND:      w_state_nxt = WAIT_TX;
      WAIT_TX:   if (w_tx_accept) w_state_nxt = (r_idx == LAST_IDX) ? WAIT_RESP : SEND;
      WAIT_RESP: if (rdy || w_timer_tc) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so this computes their values for the next cycle.
  always_comb begin
    w_cmd_nxt      = r_cmd;
    w_idx_nxt      = r_idx;
    w_tx_skip_nxt  = (r_state == SEND);
    w_clr_rdy_nxt  = 1'b0;
    w_resp_rdy_nxt = r_resp_rdy;
    w_resp_nxt     = r_resp;
    w_resp_ack_nxt = r_resp_ack;
    w_timeout_nxt  = r_timeout;
    w_timer_clr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (send_cmd) begin
          w_cmd_nxt      = cmd;
          w_idx_nxt      = '0;
          w_clr_rdy_nxt  = 1'b1;
          w_resp_rdy_nxt = 1'b0;
          w_resp_ack_nxt = 1'b0;
          w_timeout_nxt  = 1'b0;
        end
      end
      WAIT_TX: begin
        if (w_tx_accept) begin
          if (r_idx == LAST_IDX) w_timer_clr = 1'b1;
          else                   w_idx_nxt   = r_idx + 2'd1;
        end
      end
      WAIT_RESP: begin
        // A byte on the terminal-count cycle still counts as a response.
        if (rdy) begin
          w_resp_nxt     = rx_data;
          w_resp_rdy_nxt = 1'b1;
          w_resp_ack_nxt = (rx_data == ACK_BYTE);
          w_clr_rdy_nxt  = 1'b1;
        end else if (w_timer_tc) begin
          w_timeout_nxt = 1'b1;
        end
      end
      default: ;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
    w_trmt_nxt = (w_state_nxt == SEND);
  end

  always_comb begin
    w_tx_data_nxt = r_tx_data;
    if (w_state_nxt == SEND) begin
      case (w_idx_nxt)
        2'd0:    w_tx_data_nxt = w_cmd_nxt[23:16];
        2'd1:    w_tx_data_nxt = w_cmd_nxt[15:8];
        default: w_tx_data_nxt = w_cmd_nxt[7:0];
      endcase
    end
  end

  assign busy     = r_busy;
  assign trmt     = r_trmt;
  assign tx_data  = r_tx_data;
  assign clr_rdy  = r_clr_rdy;
  assign resp_rdy = r_resp_rdy;
  assign resp     = r_resp;
  assign resp_ack = r_resp_ack;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Scoreboard bench for uart_cmd_sender: stimulus queues expected bytes and
// completions, a negedge monitor pops and compares them as the DUT emits them.
module tb_uart_cmd_sender;

  localparam int TO     = 100;
  localparam int TX_DLY = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] cmd;
  logic        send_cmd;
  logic        busy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        rdy;
  logic [7:0]  rx_data;
  logic        clr_rdy;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        resp_ack;
  logic        timeout;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] b;
    bit         first;
  } tx_exp_t;

  typedef struct {
    logic       rr;
    logic [7:0] rsp;
    logic       ack;
    logic       to;
    int         delta;
  } done_exp_t;

  tx_exp_t   exp_tx[$];
  done_exp_t exp_done[$];

  uart_cmd_sender #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .send_cmd (send_cmd),
    .busy     (busy),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .rdy      (rdy),
    .rx_data  (rx_data),
    .clr_rdy  (clr_rdy),
    .resp_rdy (resp_rdy),
    .resp     (resp),
    .resp_ack (resp_ack),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transmitter model: tx_done drops two cycles after trmt (lagging clear),
  // rises TX_DLY cycles after trmt.
  initial begin
    int cnt;
    cnt = 0;
    tx_done = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (trmt === 1'b1) begin
        cnt = TX_DLY;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == TX_DLY - 2) tx_done = 1'b0;
        if (cnt == 0)          tx_done = 1'b1;
      end
    end
  end

  // Monitor
  initial begin
    logic      prev_busy;
    int        last_trmt;
    tx_exp_t   et;
    done_exp_t ed;
    prev_busy = 1'b0;
    last_trmt = -1;
    forever begin
      @(negedge clk);
      if (trmt === 1'b1) begin
        chk("busy_at_trmt", busy, 1);
        if (exp_tx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_trmt: actual tx_data=%0h required=no trmt", tx_data);
        end else begin
          et = exp_tx.pop_front();
          chk("tx_data", tx_data, et.b);
          if (!et.first) chk("trmt_gap", cyc - last_trmt, TX_DLY + 1);
        end
        last_trmt = cyc;
      end
      if (prev_busy === 1'b1 && busy === 1'b0) begin
        if (exp_done.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: actual busy fall at cycle %0d required=none", cyc);
        end else begin
          ed = exp_done.pop_front();
          chk("done_resp_rdy", resp_rdy, ed.rr);
          chk("done_resp", resp, ed.rsp);
          chk("done_resp_ack", resp_ack, ed.ack);
          chk("done_timeout", timeout, ed.to);
          if (ed.delta >= 0) chk("done_latency", cyc - last_trmt, ed.delta);
        end
      end
      prev_busy = busy;
    end
  end

  // Called at a negedge with the DUT idle; returns at the acceptance cycle.
  task automatic send(input logic [23:0] c, input done_exp_t d, input logic [7:0] prev_resp);
    exp_tx.push_back('{c[23:16], 1'b1});
    exp_tx.push_back('{c[15:8], 1'b0});
    exp_tx.push_back('{c[7:0], 1'b0});
    exp_done.push_back(d);
    cmd = c;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    chk("acc_clr_rdy", clr_rdy, 1);
    chk("acc_busy", busy, 1);
    chk("acc_trmt", trmt, 1);
    chk("acc_resp_rdy", resp_rdy, 0);
    chk("acc_resp_ack", resp_ack, 0);
    chk("acc_timeout", timeout, 0);
    chk("acc_resp_kept", resp, prev_resp);
  endtask

  task automatic wait_trmt(output int c);
    c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (trmt === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      total++;
      bad++;
      $display("FAIL wait_trmt: actual=no trmt in 100 cycles required=trmt");
      c = cyc;
    end
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b0) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_idle: actual=busy after 300 cycles required=idle");
    end
  endtask

  // Raise rdy at negedge c3+d; the capture must show at cycle c3+d+1.
  task automatic respond(input int c3, input int d, input logic [7:0] b);
    bit found;
    found = 1'b0;
    while (cyc < c3 + d) @(negedge clk);
    rdy = 1'b1;
    rx_data = b;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (clr_rdy === 1'b1) found = 1'b1;
    end
    if (found) begin
      chk("resp_clr_cycle", cyc, c3 + d + 1);
    end else begin
      total++;
      bad++;
      $display("FAIL resp_clr_rdy: actual=no pulse required=pulse");
    end
    rdy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c1, c2, c3;
    rst = 1'b1;
    cmd = 24'h0;
    send_cmd = 1'b0;
    rdy = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_busy", busy, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_clr_rdy", clr_rdy, 0);
    chk("rst_resp_rdy", resp_rdy, 0);
    chk("rst_resp_ack", resp_ack, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_resp", resp, 8'h00);

    // ACK about 50 cycles after the third tx_done
    send(24'h123456, '{1'b1, 8'hA5, 1'b1, 1'b0, 62}, 8'h00);
    wait_trmt(c2);
    wait_trmt(c3);
    respond(c3, 61, 8'hA5);

    // Back-to-back in the first idle cycle; ignored send_cmd; timeout
    send(24'hABCDEF, '{1'b0, 8'hA5, 1'b0, 1'b1, TO + TX_DLY + 1}, 8'hA5);
    repeat (3) @(negedge clk);
    cmd = 24'hFFFFFF;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    wait_trmt(c2);
    wait_trmt(c3);
    wait_idle();
    @(negedge clk);
    chk("timeout_sticky", timeout, 1);

    // Stale byte while idle is not captured and is flushed at acceptance
    rdy = 1'b1;
    rx_data = 8'h77;
    repeat (2) @(negedge clk);
    chk("stale_not_captured", resp_rdy, 0);
    chk("stale_resp_kept", resp, 8'hA5);
    send(24'h010203, '{1'b1, 8'hEE, 1'b0, 1'b0, TO + TX_DLY + 1}, 8'hA5);
    rdy = 1'b0;
    wait_trmt(c2);
    wait_trmt(c3);
    // rdy sampled exactly on the terminal-count edge
    respond(c3, TO + TX_DLY, 8'hEE);
    @(negedge clk);
    chk("clr_rdy_single", clr_rdy, 0);
    chk("nak_resp_held", resp, 8'hEE);

    // Reset one cycle after the first trmt
    repeat (2) @(negedge clk);
    send(24'h5AC33C, '{1'b0, 8'h00, 1'b0, 1'b0, -1}, 8'hEE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_tx.delete();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_trmt", trmt, 0);
    chk("mid_rst_clr_rdy", clr_rdy, 0);
    chk("mid_rst_resp_rdy", resp_rdy, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    chk("mid_rst_resp", resp, 8'h00);
    repeat (20) @(negedge clk);

    // Fresh command after reset, response at the earliest possible cycle
    send(24'h9E1180, '{1'b1, 8'hA5, 1'b1, 1'b0, TX_DLY + 2}, 8'h00);
    wait_trmt(c2);
    wait_trmt(c3);
    respond(c3, TX_DLY + 1, 8'hA5);
    @(negedge clk);
    chk("clr_rdy_single2", clr_rdy, 0);
    chk("final_busy", busy, 0);

    repeat (5) @(negedge clk);
    chk("exp_tx_drained", exp_tx.size(), 0);
    chk("exp_done_drained", exp_done.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
